// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states and sizing.
package bin_to_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ten internal digits hold any 32-bit magnitude (max 4294967295).
    localparam int          INT_DIGITS  = 10;
    localparam int          BCD_W       = 4 * INT_DIGITS;
    localparam int          ITERATIONS  = 32;
    localparam int          CNT_W       = 6;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between a requester and the converter.
interface bin_to_bcd_converter_if #(
    parameter int OUT_DIGITS = 8
);
    logic                    start;
    logic [31:0]             binary_in;
    logic                    signed_mode;
    logic [4*OUT_DIGITS-1:0] decimal;
    logic                    bcd_valid;
    logic                    busy;
    logic                    overflow;
    logic                    negative;

    modport master (
        output start, binary_in, signed_mode,
        input  decimal, bcd_valid, busy, overflow, negative
    );

    modport slave (
        input  start, binary_in, signed_mode,
        output decimal, bcd_valid, busy, overflow, negative
    );
endinterface

// File: rtl/bin_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential 32-bit binary to packed BCD converter (double-dabble, one bit per
// clock), with optional two's complement input and overflow blanking.
module bin_to_bcd_converter
    import bin_to_bcd_converter_pkg::*;
#(
    parameter int OUT_DIGITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bin_to_bcd_converter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS);

    state_t                  state_q, state_d;
    logic [BCD_W-1:0]        bcd_q;
    logic [BCD_W-1:0]        bcd_adj;
    logic [31:0]             mag_q;
    logic [31:0]             mag_in;
    logic [BCD_W+31:0]       shifted;
    logic [CNT_W-1:0]        cnt_q;
    logic                    neg_cap_q;
    logic                    neg_in;
    logic                    over_int;
    logic [4*OUT_DIGITS-1:0] decimal_q;
    logic                    overflow_q;
    logic                    negative_q;

    // Replace every visible digit with the blank code when the value does not fit.
    function automatic logic [4*OUT_DIGITS-1:0] saturate_decimal(
        input logic [4*OUT_DIGITS-1:0] low_digits,
        input logic                    ovf
    );
        logic [4*OUT_DIGITS-1:0] res;
        res = low_digits;
        if (ovf) begin
            for (int i = 0; i < OUT_DIGITS; i++) begin
                res[4*i +: 4] = BLANK_DIGIT;
            end
        end
        return res;
    endfunction

    // Magnitude is formed in 32-bit unsigned so 0x80000000 stays 2147483648.
    assign neg_in  = bus.signed_mode & bus.binary_in[31];
    assign mag_in  = neg_in ? (~bus.binary_in + 32'd1) : bus.binary_in;
    assign shifted = {bcd_adj, mag_q} << 1;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (bcd_q[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
        );
    end

    // Overflow: any internal digit beyond the displayed ones is nonzero.
    always_comb begin
        over_int = 1'b0;
        for (int i = OUT_DIGITS; i < INT_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) over_int = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; SHIFT exits once all 32 bits have been shifted in.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while counting, register result on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q      <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            neg_cap_q  <= 1'b0;
            decimal_q  <= '0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mag_q     <= mag_in;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        neg_cap_q <= neg_in;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST_CNT) begin
                        bcd_q <= shifted[BCD_W+31:32];
                        mag_q <= shifted[31:0];
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        decimal_q  <= saturate_decimal(bcd_q[4*OUT_DIGITS-1:0], over_int);
                        overflow_q <= over_int;
                        negative_q <= neg_cap_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.decimal   = decimal_q;
    assign bus.overflow  = overflow_q;
    assign bus.negative  = negative_q;
    assign bus.bcd_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter with a result scoreboard.
module tb_bin_to_bcd_converter;

    typedef struct packed {
        logic [31:0] dec;
        logic        ovf;
        logic        neg;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   n_valid;
    int   last_valid_cyc;
    int   valid_hist[$];
    exp_t sb[$];

    bin_to_bcd_converter_if #(.OUT_DIGITS(8)) bus_if ();

    bin_to_bcd_converter #(.OUT_DIGITS(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] v, input logic sm);
        exp_t        e;
        logic [31:0] m;
        e.neg = sm & v[31];
        m     = e.neg ? (32'd0 - v) : v;
        e.ovf = (m > 32'd99999999);
        e.dec = '0;
        if (e.ovf) begin
            e.dec = 32'hFFFFFFFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                e.dec[4*i +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Output monitor: every bcd_valid cycle pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.bcd_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                valid_hist.push_back(cyc);
                n_vec++;
                assert (sb.size() > 0) else begin
                    n_err++;
                    $error("FAIL sb_empty: observed unexpected bcd_valid expected none");
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("decimal", bus_if.decimal, e.dec);
                    check("overflow", 32'(bus_if.overflow), 32'(e.ovf));
                    check("negative", 32'(bus_if.negative), 32'(e.neg));
                end
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after E34.
    task automatic convert(input logic [31:0] v, input logic sm);
        int n0;
        int sc;
        bit seen;
        sb.push_back(model(v, sm));
        n0 = n_valid;
        bus_if.binary_in   = v;
        bus_if.signed_mode = sm;
        bus_if.start       = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        sc = cyc;
        check("busy_run", 32'(bus_if.busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (n_valid != n0) seen = 1'b1;
        end
        check("one_pulse", 32'(n_valid - n0), 32'd1);
        check("latency", 32'(last_valid_cyc - sc), 32'd33);
        check("busy_idle", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int n0;
        int s0;
        n_vec = 0; n_err = 0; cyc = 0; n_valid = 0; last_valid_cyc = 0;
        reset              = 1'b1;
        bus_if.start       = 1'b0;
        bus_if.binary_in   = '0;
        bus_if.signed_mode = 1'b0;

        // Reset state
        #2;
        check("rst_decimal", bus_if.decimal, 32'd0);
        check("rst_valid", 32'(bus_if.bcd_valid), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_ovf", 32'(bus_if.overflow), 32'd0);
        check("rst_neg", 32'(bus_if.negative), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Unsigned conversions and overflow boundary
        convert(32'd12345678, 1'b0);
        check("c12345678", bus_if.decimal, 32'h12345678);
        convert(32'd99999999, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("hold_decimal", bus_if.decimal, 32'h99999999);
        convert(32'd100000000, 1'b0);
        check("c1e8_dec", bus_if.decimal, 32'hFFFFFFFF);
        check("c1e8_ovf", 32'(bus_if.overflow), 32'd1);
        convert(32'hFFFFFFFF, 1'b0);
        check("cmax_ovf", 32'(bus_if.overflow), 32'd1);

        // Signed conversions
        convert(32'hFFFFFFFF, 1'b1);
        check("sneg1", bus_if.decimal, 32'h00000001);
        convert(32'hFFFFFF85, 1'b1);
        check("sneg123", bus_if.decimal, 32'h00000123);
        convert(32'h80000000, 1'b1);
        check("smin_ovf", 32'(bus_if.overflow), 32'd1);
        check("smin_neg", 32'(bus_if.negative), 32'd1);
        convert(32'd4096, 1'b1);

        // Random values
        for (int i = 0; i < 4; i++) begin
            convert(32'($urandom_range(0, 99999999)), 1'($urandom_range(0, 1)));
            convert($urandom, 1'($urandom_range(0, 1)));
        end

        // Start pulses at cycles 5 and 33 of a conversion are ignored
        n0 = n_valid;
        sb.push_back(model(32'd555, 1'b0));
        bus_if.binary_in = 32'd555; bus_if.signed_mode = 1'b0; bus_if.start = 1'b1;
        @(posedge clk); #1 bus_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus_if.start = 1'b1;
        @(posedge clk); #1 bus_if.start = 1'b0;
        repeat (27) @(posedge clk);
        #1 bus_if.start = 1'b1;
        @(posedge clk); #1 bus_if.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("ignore_pulses", 32'(n_valid - n0), 32'd1);
        check("ignore_busy", 32'(bus_if.busy), 32'd0);

        // Start held high: back-to-back conversions 35 cycles apart
        n0 = n_valid;
        valid_hist.delete();
        sb.push_back(model(32'd7, 1'b0));
        sb.push_back(model(32'd7, 1'b0));
        bus_if.binary_in = 32'd7; bus_if.start = 1'b1;
        @(posedge clk); #1;
        s0 = cyc;
        repeat (36) @(posedge clk);
        #1 bus_if.start = 1'b0;
        for (int i = 0; i < 60 && (n_valid - n0) < 2; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("held_pulses", 32'(n_valid - n0), 32'd2);
        if (valid_hist.size() >= 2) begin
            check("held_first", 32'(valid_hist[0] - s0), 32'd33);
            check("held_period", 32'(valid_hist[1] - valid_hist[0]), 32'd35);
        end

        // Reset at cycle 10 aborts a conversion of 42
        n0 = n_valid;
        bus_if.binary_in = 32'd42; bus_if.start = 1'b1;
        @(posedge clk); #1 bus_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_decimal", bus_if.decimal, 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_valid", 32'(bus_if.bcd_valid), 32'd0);
        check("abort_neg", 32'(bus_if.negative), 32'd0);
        bus_if.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus_if.start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_valid", 32'(n_valid - n0), 32'd0);
        check("abort_idle", 32'(bus_if.busy), 32'd0);

        // Zero with signed mode
        convert(32'd0, 1'b1);
        check("zero_dec", bus_if.decimal, 32'h00000000);
        check("zero_neg", 32'(bus_if.negative), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
